seq_alu_core: RTL and testbench
===============================

Name: seq_alu_core

Overview:
- Parametrised multi-cycle integer ALU core; successor to the fixed-width BEGIN/END one-hot controller.
- Controller and datapath are merged in one block.
- Operations: signed add, sub, radix-4 Booth multiply and restoring divide, all at WIDTH bits.
- Uses valid/ready handshakes on operand and result sides instead of INBUS/OUTBUS pulses.
- Reports divide-by-zero and division overflow.
- Sits between the operand front-end and the result sink of the ALU top level.

Parameters:
- WIDTH, 16: operand width; must be even and ≥4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, not overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operands/op offered.
- in_ready  out  1  core can accept.
- op_code  in  2  00 add, 01 sub, 10 mul, 11 div.
- opa  in  WIDTH  signed operand A; dividend for div.
- opb  in  WIDTH  signed operand B; divisor for div.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts result.
- result_hi  out  WIDTH  upper result word; remainder for div.
- result_lo  out  WIDTH  lower result word; quotient for div.
- div_by_zero  out  1  div issued with opb==0.
- div_overflow  out  1  div of -2^(WIDTH-1) by -1.
- state_debug  out  3  current state encoding.

Behaviour:
- Reset:
  - While reset==0 at a clock edge: state←IDLE; result_hi, result_lo, div_by_zero, div_overflow and out_valid←0.
  - in_ready is forced 0 while reset is low.
  - Reset mid-operation abandons the operation; no partial result is emitted.
- in_ready = (state==IDLE) & reset.
- Accept edge E0: in_valid & in_ready.
  - op_code, opa and opb are latched at E0.
  - in_valid in any other state is ignored.
- States: IDLE, ADDSUB, MUL_STEP, DIV_STEP, DIV_FIX, DONE. From IDLE at E0:
  - add/sub → ADDSUB.
  - mul → MUL_STEP, with counter←0 and product register {A=0, Q=opa, q-1=0}.
  - div, opb≠0 → DIV_STEP, with |opa| and |opb| latched, the sign flags saved, and counter←0.
  - div, opb==0 → DONE directly: result_hi=opa, result_lo=all ones, div_by_zero=1.
- ADDSUB, one edge → DONE:
  - Result is the exact (WIDTH+1)-bit signed opa±opb, sign-extended to 2·WIDTH.
  - Low WIDTH bits go to result_lo, the rest to result_hi.
- MUL_STEP, one Booth digit per edge:
  - Digit recoded from {Q[1],Q[0],q-1} to {0,±M,±2M}.
  - Add into A at WIDTH+2 bits, then arithmetic right shift by 2.
  - After WIDTH/2 edges → DONE.
  - {result_hi,result_lo} is the signed 2·WIDTH product.
- DIV_STEP, one restoring step per edge:
  - Shift the partial remainder left, trial-subtract |opb|, shift the quotient bit into Q.
  - After WIDTH edges → DIV_FIX.
- DIV_FIX, one edge → DONE:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if opa<0.
  - Quotient truncates toward zero.
  - For opa=-2^(WIDTH-1), opb=-1: quotient wraps to 0x8..0, remainder is 0, div_overflow=1.
- Latency from E0 until out_valid is high:
  - add/sub: after E0+1.
  - mul: after E0+WIDTH/2.
  - div: after E0+WIDTH+1.
  - div-by-zero: after E0.
- DONE:
  - out_valid=1.
  - result_hi, result_lo and the flags are held stable until out_valid & out_ready.
  - On that edge → IDLE; out_valid falls; flags clear.
  - in_ready rises the cycle after the result handshake; same-cycle result-out/operand-in overlap is not supported.
- Flags:
  - Flags are 0 for every op other than div.
  - Flags are registered and valid only with out_valid.

Decomposition:
- Package seq_alu_pkg holds:
  - op_code constants OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - State encodings S_IDLE..S_DONE (3-bit binary).
  - Booth digit select encodings.
- Sub-module booth_radix4_recode: combinational; input is 3 bits; outputs are sel_zero, sel_2m and negate. It is instantiated once.
- Counter and datapath registers stay inside seq_alu_core.

Test Plan (WIDTH=16):
- ADD opa=0x7FFF, opb=0x0001 → result_hi=0x0000, result_lo=0x8000; out_valid high after E0+1; flags 0.
- MUL opa=0xFFFD (-3), opb=0x0007 → {hi,lo}=0xFFFF_FFEB; out_valid after E0+8. Also MUL 0x8000×0x8000 → 0x4000_0000.
- DIV opa=0xFFF9 (-7), opb=0x0002 → result_lo=0xFFFD, result_hi=0xFFFF; out_valid after E0+17.
- DIV 0x8000/0xFFFF → result_lo=0x8000, result_hi=0, div_overflow=1. DIV 0x0005/0 → result_lo=0xFFFF, result_hi=0x0005, div_by_zero=1; out_valid after E0.
- Backpressure: hold out_ready=0 for 5 cycles while pulsing in_valid → outputs unchanged, in_ready=0, extra operands ignored; out_ready=1 → IDLE, in_ready=1 next cycle.
- Reset low after 3 MUL steps → after that edge out_valid=0, results 0, state_debug=IDLE; in_ready=1 once reset returns high.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential ALU core.
// Covers op codes, FSM state encodings and Booth digit select codes.
package seq_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDSUB   = 3'd1,
        S_MUL_STEP = 3'd2,
        S_DIV_STEP = 3'd3,
        S_DIV_FIX  = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    // Booth digit select, packed as {sel_zero, sel_2m, negate}
    localparam logic [2:0] BOOTH_ZERO = 3'b100;
    localparam logic [2:0] BOOTH_P1   = 3'b000;
    localparam logic [2:0] BOOTH_P2   = 3'b010;
    localparam logic [2:0] BOOTH_N1   = 3'b001;
    localparam logic [2:0] BOOTH_N2   = 3'b011;

endpackage

// File: rtl/booth_radix4_recode.sv
// Radix-4 Booth recoder: maps {Q[1],Q[0],q-1} to a digit in {0, +-M, +-2M}.
module booth_radix4_recode
    import seq_alu_pkg::*;
(
    input  logic [2:0] bits,
    output logic       sel_zero,
    output logic       sel_2m,
    output logic       negate
);

    logic [2:0] sel;

    always_comb begin
        sel = BOOTH_ZERO;
        unique case (bits)
            3'b000, 3'b111: sel = BOOTH_ZERO;
            3'b001, 3'b010: sel = BOOTH_P1;
            3'b011:         sel = BOOTH_P2;
            3'b100:         sel = BOOTH_N2;
            default:        sel = BOOTH_N1;
        endcase
    end

    assign {sel_zero, sel_2m, negate} = sel;

endmodule

// File: rtl/seq_alu_core.sv
// Multi-cycle signed ALU core: add/sub, radix-4 Booth multiply, restoring divide,
// with valid/ready handshakes on operand and result sides.
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero,
    output logic             div_overflow,
    output logic [2:0]       state_debug
);

    localparam int AW = WIDTH + 2;

    state_e             state_reg, state_next;
    logic [1:0]         op_reg, op_next;
    logic [AW-1:0]      acc_reg, acc_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic               qm1_reg, qm1_next;
    logic [WIDTH-1:0]   m_reg, m_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               sign_q_reg, sign_q_next;
    logic               sign_r_reg, sign_r_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               dbz_reg, dbz_next;
    logic               ovf_reg, ovf_next;

    logic               sel_zero, sel_2m, negate;
    logic [AW-1:0]      m_ext, addend, booth_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH:0]     as_a, as_b, as_sum;
    logic [WIDTH-1:0]   abs_a, abs_b, q_fix, r_fix;

    booth_radix4_recode u_recode (
        .bits     ({q_reg[1:0], qm1_reg}),
        .sel_zero (sel_zero),
        .sel_2m   (sel_2m),
        .negate   (negate)
    );

    always_comb begin
        m_ext     = {{2{m_reg[WIDTH-1]}}, m_reg};
        addend    = sel_zero ? '0 : (sel_2m ? (m_ext << 1) : m_ext);
        addend    = negate ? -addend : addend;
        booth_sum = acc_reg + addend;

        div_shift = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, m_reg};

        as_a   = {q_reg[WIDTH-1], q_reg};
        as_b   = {m_reg[WIDTH-1], m_reg};
        as_sum = (op_reg == OP_SUB) ? (as_a - as_b) : (as_a + as_b);

        abs_a = opa[WIDTH-1] ? -opa : opa;
        abs_b = opb[WIDTH-1] ? -opb : opb;
        q_fix = sign_q_reg ? -q_reg : q_reg;
        r_fix = sign_r_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        acc_next    = acc_reg;
        q_next      = q_reg;
        qm1_next    = qm1_reg;
        m_next      = m_reg;
        cnt_next    = cnt_reg;
        sign_q_next = sign_q_reg;
        sign_r_next = sign_r_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        dbz_next    = dbz_reg;
        ovf_next    = ovf_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    op_next  = op_code;
                    acc_next = '0;
                    q_next   = opa;
                    qm1_next = 1'b0;
                    m_next   = opb;
                    cnt_next = '0;
                    unique case (op_code)
                        OP_ADD, OP_SUB: state_next = S_ADDSUB;
                        OP_MUL:         state_next = S_MUL_STEP;
                        default: begin
                            if (opb == '0) begin
                                hi_next    = opa;
                                lo_next    = '1;
                                dbz_next   = 1'b1;
                                state_next = S_DONE;
                            end else begin
                                q_next      = abs_a;
                                m_next      = abs_b;
                                sign_q_next = opa[WIDTH-1] ^ opb[WIDTH-1];
                                sign_r_next = opa[WIDTH-1];
                                state_next  = S_DIV_STEP;
                            end
                        end
                    endcase
                end
            end
            S_ADDSUB: begin
                {hi_next, lo_next} = {{(WIDTH-1){as_sum[WIDTH]}}, as_sum};
                state_next = S_DONE;
            end
            S_MUL_STEP: begin
                acc_next = {{2{booth_sum[AW-1]}}, booth_sum[AW-1:2]};
                q_next   = {booth_sum[1:0], q_reg[WIDTH-1:2]};
                qm1_next = q_reg[1];
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH/2 - 1)) begin
                    hi_next    = acc_next[WIDTH-1:0];
                    lo_next    = q_next;
                    state_next = S_DONE;
                end
            end
            S_DIV_STEP: begin
                acc_next = div_diff[WIDTH+1] ? {1'b0, div_shift} : {1'b0, div_diff[WIDTH:0]};
                q_next   = {q_reg[WIDTH-2:0], ~div_diff[WIDTH+1]};
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1))
                    state_next = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                lo_next = q_fix;
                hi_next = r_fix;
                // A non-negative quotient magnitude of 2^(WIDTH-1) only arises from MIN / -1.
                ovf_next   = ~sign_q_reg & q_reg[WIDTH-1];
                state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    dbz_next   = 1'b0;
                    ovf_next   = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            acc_reg    <= '0;
            q_reg      <= '0;
            qm1_reg    <= 1'b0;
            m_reg      <= '0;
            cnt_reg    <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            dbz_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            acc_reg    <= acc_next;
            q_reg      <= q_next;
            qm1_reg    <= qm1_next;
            m_reg      <= m_next;
            cnt_reg    <= cnt_next;
            sign_q_reg <= sign_q_next;
            sign_r_reg <= sign_r_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            dbz_reg    <= dbz_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign in_ready     = (state_reg == S_IDLE) & reset;
    assign out_valid    = (state_reg == S_DONE);
    assign result_hi    = hi_reg;
    assign result_lo    = lo_reg;
    assign div_by_zero  = dbz_reg;
    assign div_overflow = ovf_reg;
    assign state_debug  = state_reg;

endmodule

// File: tb/tb_seq_alu_core.sv
// Randomized self-checking bench for seq_alu_core against an arithmetic reference model.
module tb_seq_alu_core;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] opa, opb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_hi, result_lo;
    logic             div_by_zero, div_overflow;
    logic [2:0]       state_debug;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_alu_core #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_code      (op_code),
        .opa          (opa),
        .opb          (opb),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result_hi    (result_hi),
        .result_lo    (result_lo),
        .div_by_zero  (div_by_zero),
        .div_overflow (div_overflow),
        .state_debug  (state_debug)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain signed arithmetic on 64-bit integers.
    function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] hi, output logic [15:0] lo,
                                  output logic dbz, output logic ovf, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        ovf = 1'b0;
        p   = '0;
        case (op)
            2'd0: begin p = sa + sb; lat = 1; end
            2'd1: begin p = sa - sb; lat = 1; end
            2'd2: begin p = sa * sb; lat = WIDTH / 2; end
            default: begin
                if (sb == 0) begin
                    p   = {32'd0, a, 16'hFFFF};
                    dbz = 1'b1;
                    lat = 0;
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    ovf = (q > 32767);
                    p   = {32'd0, r[15:0], q[15:0]};
                    lat = WIDTH + 1;
                end
            end
        endcase
        hi = p[31:16];
        lo = p[15:0];
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] e_hi, e_lo;
        logic        e_dbz, e_ovf;
        int          e_lat, lat;
        model(op, a, b, e_hi, e_lo, e_dbz, e_ovf, e_lat);
        check_val("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        op_code  = op;
        opa      = a;
        opb      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opa      = 16'($urandom);
        opb      = 16'($urandom);
        op_code  = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", lat, e_lat);
        check_val("result_hi", result_hi, e_hi);
        check_val("result_lo", result_lo, e_lo);
        check_val("div_by_zero", div_by_zero, e_dbz);
        check_val("div_overflow", div_overflow, e_ovf);
        check_val("state_done", state_debug, 3'd5);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            opa      = 16'($urandom);
            opb      = 16'($urandom);
            op_code  = 2'($urandom);
            @(posedge clk); #1;
            check_val("hold_out_valid", out_valid, 1);
            check_val("hold_in_ready", in_ready, 0);
            check_val("hold_hi", result_hi, e_hi);
            check_val("hold_lo", result_lo, e_lo);
            check_val("hold_dbz", div_by_zero, e_dbz);
            check_val("hold_ovf", div_overflow, e_ovf);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("post_out_valid", out_valid, 0);
        check_val("post_in_ready", in_ready, 1);
        check_val("post_state", state_debug, 3'd0);
        check_val("post_dbz", div_by_zero, 0);
        check_val("post_ovf", div_overflow, 0);
        $display("op=%0d a=%h b=%h hold=%0d -> hi=%h lo=%h dbz=%0b ovf=%0b lat=%0d (exp hi=%h lo=%h)",
                 op, a, b, hold, e_hi, e_lo, e_dbz, e_ovf, lat, e_hi, e_lo);
    endtask

    task automatic reset_mid_mul(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        op_code  = 2'd2;
        opa      = a;
        opb      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_hi", result_hi, 0);
        check_val("rst_lo", result_lo, 0);
        check_val("rst_state", state_debug, 3'd0);
        check_val("rst_in_ready_low", in_ready, 0);
        reset = 1'b1;
        #1;
        check_val("rst_in_ready_high", in_ready, 1);
        repeat (WIDTH) @(posedge clk);
        #1;
        check_val("rst_no_partial", out_valid, 0);
        $display("reset during MUL a=%h b=%h abandoned", a, b);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'h7FFF;
            4:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_code   = 2'd0;
        opa       = '0;
        opb       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_in_ready", in_ready, 0);
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_hi", result_hi, 0);
        check_val("reset_lo", result_lo, 0);
        check_val("reset_state", state_debug, 3'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(2'd0, 16'h7FFF, 16'h0001, 0);
        run_op(2'd2, 16'hFFFD, 16'h0007, 0);
        run_op(2'd2, 16'h8000, 16'h8000, 0);
        run_op(2'd3, 16'hFFF9, 16'h0002, 0);
        run_op(2'd3, 16'h8000, 16'hFFFF, 0);
        run_op(2'd3, 16'h0005, 16'h0000, 5);
        run_op(2'd1, 16'h8000, 16'h0001, 5);
        reset_mid_mul(16'h1234, 16'h0567);
        run_op(2'd2, 16'h7FFF, 16'h8000, 2);

        for (int n = 0; n < 150; n++)
            run_op(2'($urandom), pick_operand(), pick_operand(), int'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
